// File: rtl/axi_uncache_bridge.sv
// rtl/axi_uncache_bridge.sv - single-beat AXI3 master for uncached dcache reads/writes
// Optional posted-write completion: UNCACHE_POSTED_WRITE_EN
module axi_uncache_bridge #(
  parameter int unsigned          ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0]  RD_ID    = ID_WIDTH'(2),
  parameter logic [ID_WIDTH-1:0]  WR_ID    = ID_WIDTH'(2)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                rd_req,
  input  logic [31:0]         rd_addr,
  input  logic [1:0]          rd_size,
  output logic                rd_rdy,
  output logic                ret_valid,
  output logic [31:0]         ret_data,
  input  logic                wr_req,
  input  logic [31:0]         wr_addr,
  input  logic [31:0]         wr_data,
  input  logic [3:0]          wr_wstrb,
  output logic                wr_rdy,
  output logic                wr_valid,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_WIDTH-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_WIDTH-1:0] wid,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_WIDTH-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

`ifdef UNCACHE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_AR  = 3'd1;
  localparam logic [2:0] S_RD_R   = 3'd2;
  localparam logic [2:0] S_WR_AWW = 3'd3;
  localparam logic [2:0] S_WR_B   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] ret_data_q, ret_data_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  size_q, size_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        ret_valid_q, ret_valid_d;
  logic        wr_valid_q, wr_valid_d;
  logic        aw_done, w_done;
  logic [2:0]  awsize_c;
  logic        unused_resp;

  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      ret_data_q  <= '0;
      wstrb_q     <= '0;
      size_q      <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      ret_valid_q <= 1'b0;
      wr_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ret_data_q  <= ret_data_d;
      wstrb_q     <= wstrb_d;
      size_q      <= size_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      ret_valid_q <= ret_valid_d;
      wr_valid_q  <= wr_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    ret_data_d  = ret_data_q;
    wstrb_d     = wstrb_q;
    size_d      = size_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    ret_valid_d = 1'b0;
    wr_valid_d  = 1'b0;
    // AW and W retire independently; a channel already retired counts as done
    aw_done     = !awvalid_q || awready;
    w_done      = !wvalid_q || wready;
    case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          addr_d     = wr_addr;
          data_d     = wr_data;
          wstrb_d    = wr_wstrb;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          wr_valid_d = POSTED;
          state_d    = S_WR_AWW;
        end else if (rd_req) begin
          addr_d    = rd_addr;
          size_d    = rd_size;
          arvalid_d = 1'b1;
          state_d   = S_RD_AR;
        end
      end
      S_RD_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end
      end
      S_RD_R: begin
        if (rvalid) begin
          ret_data_d  = rdata;
          ret_valid_d = 1'b1;
          rready_d    = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_WR_AWW: begin
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = S_WR_B;
        end
      end
      S_WR_B: begin
        if (bvalid) begin
          bready_d   = 1'b0;
          wr_valid_d = !POSTED;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (wstrb_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: awsize_c = 3'd0;
      4'b0011, 4'b1100:                   awsize_c = 3'd1;
      default:                            awsize_c = 3'd2;
    endcase
  end

  assign rd_rdy    = (state_q == S_IDLE);
  assign wr_rdy    = (state_q == S_IDLE);
  assign ret_valid = ret_valid_q;
  assign ret_data  = ret_data_q;
  assign wr_valid  = wr_valid_q;

  assign arid    = RD_ID;
  assign araddr  = addr_q;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = WR_ID;
  assign awaddr  = addr_q;
  assign awlen   = 4'd0;
  assign awsize  = awsize_c;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = awvalid_q;
  assign wid     = WR_ID;
  assign wdata   = data_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: tb/tb_axi_uncache_bridge.sv
// tb/tb_axi_uncache_bridge.sv - directed vector bench for axi_uncache_bridge
`timescale 1ns/1ps
module tb_axi_uncache_bridge;

`ifdef UNCACHE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        rd_req, wr_req, rd_rdy, wr_rdy, ret_valid, wr_valid;
  logic [31:0] rd_addr, wr_addr, wr_data, ret_data;
  logic [1:0]  rd_size;
  logic [3:0]  wr_wstrb;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [3:0]  arlen, arcache, awlen, awcache, wstrb;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  axi_uncache_bridge dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_wstrb(wr_wstrb),
    .wr_rdy(wr_rdy), .wr_valid(wr_valid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  rsize;
    int          d1;
    int          d2;
    int          d3;
    logic [2:0]  exp_size;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int ret_cnt = 0;
  int wr_cnt = 0;

  always @(negedge clk) begin
    if (ret_valid) ret_cnt <= ret_cnt + 1;
    if (wr_valid)  wr_cnt  <= wr_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int b = 0;
    while (!(rd_rdy && wr_rdy) && b < 40) begin
      step();
      b++;
    end
    chk("idle_wait", 32'(rd_rdy && wr_rdy), 32'd1);
  endtask

  task automatic do_read(input vec_t v);
    int r0;
    wait_idle();
    r0 = ret_cnt;
    rd_req = 1'b1; rd_addr = v.addr; rd_size = v.rsize;
    step();
    rd_req = 1'b0; rd_addr = '0; rd_size = '0;
    chk("rd_rdy_busy", 32'(rd_rdy), 32'd0);
    chk("arsize", 32'(arsize), 32'(v.exp_size));
    chk("arid", 32'(arid), 32'd2);
    chk("arlen_burst_cache", 32'({arlen, arburst, arcache, arlock, arprot}), 32'({4'd0, 2'b01, 4'd0, 2'd0, 3'd0}));
    for (int k = 0; k <= v.d1; k++) begin
      chk("arvalid_held", 32'(arvalid), 32'd1);
      chk("araddr", araddr, v.addr);
      chk("rready_early", 32'(rready), 32'd0);
      arready = (k == v.d1);
      step();
    end
    arready = 1'b0;
    chk("arvalid_drop", 32'(arvalid), 32'd0);
    for (int k = 0; k < v.d2; k++) begin
      chk("rready_wait", 32'(rready), 32'd1);
      chk("ret_early", 32'(ret_valid), 32'd0);
      step();
    end
    chk("rready", 32'(rready), 32'd1);
    rvalid = 1'b1; rdata = v.data;
    step();
    rvalid = 1'b0; rdata = 32'hDEAD_0BAD;
    chk("ret_valid", 32'(ret_valid), 32'd1);
    chk("ret_data", ret_data, v.data);
    chk("rready_drop", 32'(rready), 32'd0);
    step();
    chk("ret_valid_1cyc", 32'(ret_valid), 32'd0);
    chk("ret_pulses", 32'(ret_cnt - r0), 32'd1);
  endtask

  task automatic do_write(input vec_t v);
    int w0;
    int last;
    wait_idle();
    w0 = wr_cnt;
    wr_req = 1'b1; wr_addr = v.addr; wr_data = v.data; wr_wstrb = v.strb;
    step();
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_wstrb = '0;
    chk("wr_rdy_busy", 32'(wr_rdy), 32'd0);
    chk("wr_valid_accept", 32'(wr_valid), 32'(POSTED));
    chk("awsize", 32'(awsize), 32'(v.exp_size));
    chk("aw_w_ids", 32'({awid, wid, wlast}), 32'({4'd2, 4'd2, 1'b1}));
    chk("awlen_burst", 32'({awlen, awburst, awcache, awlock, awprot}), 32'({4'd0, 2'b01, 4'd0, 2'd0, 3'd0}));
    last = (v.d1 > v.d2) ? v.d1 : v.d2;
    for (int k = 0; k <= last; k++) begin
      chk("awvalid", 32'(awvalid), 32'(k <= v.d1));
      chk("wvalid", 32'(wvalid), 32'(k <= v.d2));
      chk("awaddr", awaddr, v.addr);
      chk("wdata", wdata, v.data);
      chk("wstrb", 32'(wstrb), 32'(v.strb));
      chk("bready_early", 32'(bready), 32'd0);
      awready = (k == v.d1);
      wready  = (k == v.d2);
      step();
    end
    awready = 1'b0; wready = 1'b0;
    chk("aw_w_drop", 32'({awvalid, wvalid}), 32'd0);
    for (int k = 0; k < v.d3; k++) begin
      chk("bready_wait", 32'(bready), 32'd1);
      chk("wr_valid_early", 32'(wr_valid), 32'd0);
      step();
    end
    chk("bready", 32'(bready), 32'd1);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("bready_drop", 32'(bready), 32'd0);
    chk("wr_valid_b", 32'(wr_valid), 32'(!POSTED));
    chk("wr_rdy_after", 32'(wr_rdy), 32'd1);
    step();
    chk("wr_pulses", 32'(wr_cnt - w0), 32'd1);
  endtask

  vec_t vt[12];

  initial begin
    int c0;
    int w0;
    vec_t rv;
    vt[0]  = '{1'b0, 32'hBFAF_8000, 32'h1234_5678, 4'h0,    2'd2, 1, 0, 0, 3'd2};
    vt[1]  = '{1'b1, 32'hBFAF_F020, 32'h0000_00AB, 4'b0001, 2'd0, 3, 1, 1, 3'd0};
    vt[2]  = '{1'b1, 32'h1FC0_0004, 32'hDEAD_BEEF, 4'b1111, 2'd0, 0, 0, 0, 3'd2};
    vt[3]  = '{1'b1, 32'hA000_0002, 32'h5566_0000, 4'b1100, 2'd0, 0, 2, 2, 3'd1};
    vt[4]  = '{1'b1, 32'hBFD0_0010, 32'h0000_7788, 4'b0011, 2'd0, 1, 1, 0, 3'd1};
    vt[5]  = '{1'b1, 32'hBFD0_0013, 32'hC300_0000, 4'b1000, 2'd0, 2, 0, 3, 3'd0};
    vt[6]  = '{1'b1, 32'hBFD0_0021, 32'h00A5_5A00, 4'b0110, 2'd0, 0, 1, 0, 3'd2};
    vt[7]  = '{1'b0, 32'hBFD0_03F8, 32'h0000_00F0, 4'h0,    2'd0, 0, 2, 0, 3'd0};
    vt[8]  = '{1'b0, 32'hBFD0_03FA, 32'hBEEF_0000, 4'h0,    2'd1, 3, 1, 0, 3'd1};
    vt[9]  = '{1'b1, 32'hBFD0_0102, 32'h0012_0000, 4'b0100, 2'd0, 1, 0, 1, 3'd0};
    vt[10] = '{1'b1, 32'hBFD0_0101, 32'h0000_3400, 4'b0010, 2'd0, 0, 0, 4, 3'd0};
    vt[11] = '{1'b0, 32'hBFC0_0000, 32'h3C1A_BFC0, 4'h0,    2'd2, 0, 0, 0, 3'd2};

    resetn = 1'b0;
    rd_req = 1'b0; rd_addr = '0; rd_size = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_wstrb = '0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
    bid = '0; bresp = '0; bvalid = 1'b0;
    step();
    step();
    chk("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready, ret_valid, wr_valid}), 32'd0);
    chk("rst_ret_data", ret_data, 32'd0);
    chk("rst_regs", araddr | wdata, 32'd0);
    resetn = 1'b1;
    step();
    chk("idle_rdy", 32'({rd_rdy, wr_rdy}), 32'd3);

    // stray responses in IDLE must not be accepted
    c0 = ret_cnt;
    w0 = wr_cnt;
    rvalid = 1'b1; rdata = 32'hFFFF_FFFF; bvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stray_ready", 32'({rready, bready}), 32'd0);
      chk("stray_pulse", 32'({ret_valid, wr_valid}), 32'd0);
    end
    rvalid = 1'b0; bvalid = 1'b0;
    step();
    chk("stray_cnt", 32'((ret_cnt - c0) + (wr_cnt - w0)), 32'd0);
    chk("stray_data", ret_data, 32'd0);

    for (int i = 0; i < 12; i++) begin
      if (vt[i].is_wr) do_write(vt[i]);
      else             do_read(vt[i]);
    end

    // simultaneous requests: write goes first, read waits for write completion
    wait_idle();
    c0 = ret_cnt;
    w0 = wr_cnt;
    rd_req = 1'b1; rd_addr = 32'hBFAF_9004; rd_size = 2'd2;
    wr_req = 1'b1; wr_addr = 32'hBFAF_A008; wr_data = 32'h0BAD_F00D; wr_wstrb = 4'hF;
    step();
    wr_req = 1'b0;
    chk("sim_aw_w", 32'({awvalid, wvalid, arvalid}), 32'b110);
    chk("sim_rd_rdy", 32'(rd_rdy), 32'd0);
    chk("sim_awaddr", awaddr, 32'hBFAF_A008);
    chk("sim_wr_valid_acc", 32'(wr_valid), 32'(POSTED));
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0;
    chk("sim_bready", 32'(bready), 32'd1);
    chk("sim_no_ar", 32'({arvalid, rd_rdy}), 32'd0);
    step();
    chk("sim_no_ar_b", 32'({arvalid, rd_rdy}), 32'd0);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("sim_wr_valid_b", 32'(wr_valid), 32'(!POSTED));
    chk("sim_ar_after", 32'({arvalid, rd_rdy}), 32'b01);
    step();
    rd_req = 1'b0; rd_addr = '0;
    chk("sim_arvalid", 32'(arvalid), 32'd1);
    chk("sim_araddr", araddr, 32'hBFAF_9004);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h600D_CAFE;
    step();
    rvalid = 1'b0;
    chk("sim_ret", 32'(ret_valid), 32'd1);
    chk("sim_ret_data", ret_data, 32'h600D_CAFE);
    step();
    chk("sim_cnts", 32'({8'(ret_cnt - c0), 8'(wr_cnt - w0)}), 32'h0101);

    // asynchronous reset while waiting for R
    wait_idle();
    c0 = ret_cnt;
    rd_req = 1'b1; rd_addr = 32'hBFAF_8010; rd_size = 2'd2;
    step();
    rd_req = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("rst_mid_rready", 32'(rready), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_clear", 32'({arvalid, rready, ret_valid}), 32'd0);
    rvalid = 1'b1; rdata = 32'h1111_2222;
    step();
    resetn = 1'b1;
    rvalid = 1'b0;
    step();
    chk("rst_mid_noret", 32'(ret_cnt - c0), 32'd0);
    chk("rst_mid_idle", 32'({rd_rdy, wr_rdy, ret_valid}), 32'b110);
    rv = '{1'b0, 32'hBFAF_8010, 32'hA5A5_1234, 4'h0, 2'd2, 0, 1, 0, 3'd2};
    do_read(rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
